// File: rtl/associative_way_controller.sv
// associative_way_controller
// Request-side controller for a set-associative data array. Holds per-set
// tag/valid state and a round-robin victim pointer, resolves each request to
// a hit or victim way, runs a fill handshake on a miss, writes the returned
// element into the victim way, then replays the request against the array.
// All outputs are registered: the value an output carries in a given state is
// computed on the edge that enters that state.

module associative_way_controller #(
    parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 64,
    parameter int NUMBER_SETS                 = 64,
    parameter int NUMBER_WAYS                 = 4,
    parameter int TAG_WIDTH_IN_BITS           = 20,
    parameter int SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS)
) (
    input  logic                                   clk_in,
    input  logic                                   reset_in,

    input  logic                                   req_valid_in,
    output logic                                   req_ready_out,
    input  logic                                   req_write_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       req_set_in,
    input  logic [TAG_WIDTH_IN_BITS-1:0]           req_tag_in,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] req_data_in,

    output logic                                   access_en_out,
    output logic                                   write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]       access_set_addr_out,
    output logic [NUMBER_WAYS-1:0]                 way_select_out,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] write_single_data_out,

    output logic                                   fill_req_valid_out,
    input  logic                                   fill_req_ready_in,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]       fill_set_out,
    output logic [TAG_WIDTH_IN_BITS-1:0]           fill_tag_out,
    input  logic                                   fill_valid_in,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] fill_data_in,

    output logic                                   resp_valid_out,
    output logic                                   resp_hit_out,
    output logic [NUMBER_WAYS-1:0]                 resp_way_out
);

    localparam int WAY_IDX_W = $clog2(NUMBER_WAYS);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FILL_REQ,
        FILL_WAIT,
        FILL_WRITE,
        RESP
    } state_t;

    state_t state;

    // Registered request
    logic                                   req_write;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]       req_set;
    logic [TAG_WIDTH_IN_BITS-1:0]           req_tag;
    logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] req_data;
    logic                                   missed;

    // Lookup result prepared for the LOOKUP cycle, and the chosen victim
    logic                                   lookup_hit;
    logic [WAY_IDX_W-1:0]                   lookup_way;
    logic [WAY_IDX_W-1:0]                   victim_idx;
    logic                                   victim_from_ptr;

    // Per-set tag/valid state and round-robin pointer
    logic [NUMBER_WAYS-1:0]                 valid_bits [NUMBER_SETS];
    logic [TAG_WIDTH_IN_BITS-1:0]           tag_mem    [NUMBER_SETS][NUMBER_WAYS];
    logic [WAY_IDX_W-1:0]                   rr_ptr     [NUMBER_SETS];

    // Probe results for the incoming request (tag state is stable while idle)
    logic                                   probe_hit;
    logic [WAY_IDX_W-1:0]                   probe_hit_idx;
    logic                                   probe_free;
    logic [WAY_IDX_W-1:0]                   probe_free_idx;

    function automatic logic [NUMBER_WAYS-1:0] to_onehot(input logic [WAY_IDX_W-1:0] idx);
        return NUMBER_WAYS'(1) << idx;
    endfunction

    // Compare the incoming tag against every valid way of its set and find the
    // lowest free way; scanning downward lets the lowest matching index win.
    always_comb begin
        probe_hit      = 1'b0;
        probe_hit_idx  = '0;
        probe_free     = 1'b0;
        probe_free_idx = '0;
        for (int w = NUMBER_WAYS - 1; w >= 0; w--) begin
            if (valid_bits[req_set_in][w] && (tag_mem[req_set_in][w] == req_tag_in)) begin
                probe_hit     = 1'b1;
                probe_hit_idx = WAY_IDX_W'(w);
            end
            if (!valid_bits[req_set_in][w]) begin
                probe_free     = 1'b1;
                probe_free_idx = WAY_IDX_W'(w);
            end
        end
    end

    // Stored tags carry no reset value; only the valid bit qualifies them.
    always_ff @(posedge clk_in) begin
        if (state == FILL_WRITE) begin
            tag_mem[req_set][victim_idx] <= req_tag;
        end
    end

    // Controller FSM with registered outputs, valid bits and victim pointers.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state                 <= IDLE;
            req_write             <= 1'b0;
            req_set               <= '0;
            req_tag               <= '0;
            req_data              <= '0;
            missed                <= 1'b0;
            lookup_hit            <= 1'b0;
            lookup_way            <= '0;
            victim_idx            <= '0;
            victim_from_ptr       <= 1'b0;
            req_ready_out         <= 1'b1;
            access_en_out         <= 1'b0;
            write_en_out          <= 1'b0;
            access_set_addr_out   <= '0;
            way_select_out        <= '0;
            write_single_data_out <= '0;
            fill_req_valid_out    <= 1'b0;
            fill_set_out          <= '0;
            fill_tag_out          <= '0;
            resp_valid_out        <= 1'b0;
            resp_hit_out          <= 1'b0;
            resp_way_out          <= '0;
            for (int s = 0; s < NUMBER_SETS; s++) begin
                valid_bits[s] <= '0;
                rr_ptr[s]     <= '0;
            end
        end else begin
            access_en_out         <= 1'b0;
            write_en_out          <= 1'b0;
            access_set_addr_out   <= '0;
            way_select_out        <= '0;
            write_single_data_out <= '0;
            resp_valid_out        <= 1'b0;
            resp_hit_out          <= 1'b0;
            resp_way_out          <= '0;

            case (state)
                IDLE: begin
                    if (req_valid_in) begin
                        req_write       <= req_write_in;
                        req_set         <= req_set_in;
                        req_tag         <= req_tag_in;
                        req_data        <= req_data_in;
                        missed          <= 1'b0;
                        lookup_hit      <= probe_hit;
                        lookup_way      <= probe_hit_idx;
                        victim_idx      <= probe_free ? probe_free_idx : rr_ptr[req_set_in];
                        victim_from_ptr <= !probe_free;
                        req_ready_out   <= 1'b0;
                        state           <= LOOKUP;
                        if (probe_hit) begin
                            access_en_out         <= 1'b1;
                            write_en_out          <= req_write_in;
                            access_set_addr_out   <= req_set_in;
                            way_select_out        <= to_onehot(probe_hit_idx);
                            write_single_data_out <= req_data_in;
                        end
                    end
                end

                LOOKUP: begin
                    if (lookup_hit) begin
                        resp_valid_out <= 1'b1;
                        resp_hit_out   <= !missed;
                        resp_way_out   <= to_onehot(lookup_way);
                        state          <= RESP;
                    end else begin
                        missed             <= 1'b1;
                        fill_req_valid_out <= 1'b1;
                        fill_set_out       <= req_set;
                        fill_tag_out       <= req_tag;
                        state              <= FILL_REQ;
                    end
                end

                FILL_REQ: begin
                    if (fill_req_ready_in) begin
                        fill_req_valid_out <= 1'b0;
                        fill_set_out       <= '0;
                        fill_tag_out       <= '0;
                        state              <= FILL_WAIT;
                    end
                end

                FILL_WAIT: begin
                    // The returned element is held in the write-data register
                    // for the single FILL_WRITE cycle that consumes it.
                    if (fill_valid_in) begin
                        access_en_out         <= 1'b1;
                        write_en_out          <= 1'b1;
                        access_set_addr_out   <= req_set;
                        way_select_out        <= to_onehot(victim_idx);
                        write_single_data_out <= fill_data_in;
                        state                 <= FILL_WRITE;
                    end
                end

                FILL_WRITE: begin
                    valid_bits[req_set][victim_idx] <= 1'b1;
                    if (victim_from_ptr) begin
                        rr_ptr[req_set] <= rr_ptr[req_set] + WAY_IDX_W'(1);
                    end
                    // Replay: the victim now holds the tag, so LOOKUP hits there.
                    lookup_hit            <= 1'b1;
                    lookup_way            <= victim_idx;
                    access_en_out         <= 1'b1;
                    write_en_out          <= req_write;
                    access_set_addr_out   <= req_set;
                    way_select_out        <= to_onehot(victim_idx);
                    write_single_data_out <= req_data;
                    state                 <= LOOKUP;
                end

                RESP: begin
                    req_ready_out <= 1'b1;
                    state         <= IDLE;
                end

                default: begin
                    req_ready_out <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_associative_way_controller.sv
// tb_associative_way_controller
// Scoreboard bench: requests push their expected response computed by a
// behavioural cache model; a monitor pops on resp_valid_out. Also models the
// next level (fill responder) and the data array.

module tb_associative_way_controller;

    localparam int SW   = 64;
    localparam int SETS = 64;
    localparam int WAYS = 4;
    localparam int TW   = 20;
    localparam int SPW  = 6;

    logic            clk_in;
    logic            reset_in;
    logic            req_valid_in;
    logic            req_ready_out;
    logic            req_write_in;
    logic [SPW-1:0]  req_set_in;
    logic [TW-1:0]   req_tag_in;
    logic [SW-1:0]   req_data_in;
    logic            access_en_out;
    logic            write_en_out;
    logic [SPW-1:0]  access_set_addr_out;
    logic [WAYS-1:0] way_select_out;
    logic [SW-1:0]   write_single_data_out;
    logic            fill_req_valid_out;
    logic            fill_req_ready_in;
    logic [SPW-1:0]  fill_set_out;
    logic [TW-1:0]   fill_tag_out;
    logic            fill_valid_in;
    logic [SW-1:0]   fill_data_in;
    logic            resp_valid_out;
    logic            resp_hit_out;
    logic [WAYS-1:0] resp_way_out;

    associative_way_controller #(
        .SINGLE_ELEMENT_SIZE_IN_BITS(SW),
        .NUMBER_SETS(SETS),
        .NUMBER_WAYS(WAYS),
        .TAG_WIDTH_IN_BITS(TW),
        .SET_PTR_WIDTH_IN_BITS(SPW)
    ) dut (
        .clk_in(clk_in),
        .reset_in(reset_in),
        .req_valid_in(req_valid_in),
        .req_ready_out(req_ready_out),
        .req_write_in(req_write_in),
        .req_set_in(req_set_in),
        .req_tag_in(req_tag_in),
        .req_data_in(req_data_in),
        .access_en_out(access_en_out),
        .write_en_out(write_en_out),
        .access_set_addr_out(access_set_addr_out),
        .way_select_out(way_select_out),
        .write_single_data_out(write_single_data_out),
        .fill_req_valid_out(fill_req_valid_out),
        .fill_req_ready_in(fill_req_ready_in),
        .fill_set_out(fill_set_out),
        .fill_tag_out(fill_tag_out),
        .fill_valid_in(fill_valid_in),
        .fill_data_in(fill_data_in),
        .resp_valid_out(resp_valid_out),
        .resp_hit_out(resp_hit_out),
        .resp_way_out(resp_way_out)
    );

    typedef struct {
        logic            is_write;
        logic [SPW-1:0]  set;
        logic [TW-1:0]   tag;
        logic            exp_hit;
        logic [WAYS-1:0] exp_way;
        logic [SW-1:0]   exp_rdata;
        int              issue_cycle;
        int              exp_latency;
    } exp_t;

    exp_t exp_q[$];

    int tests;
    int errors;
    int cycle_count;
    bit checks_on;

    // Next-level responder controls
    int          ready_delay;
    int          data_delay;
    bit          override_en;
    logic [SW-1:0] override_data;
    bit          spurious_en;

    // Behavioural cache model
    bit            m_valid [SETS][WAYS];
    logic [TW-1:0] m_tag   [SETS][WAYS];
    int            m_ptr   [SETS];
    logic [SW-1:0] m_data  [SETS][WAYS];

    // Data array model
    logic [SW-1:0] arr_mem [SETS*WAYS];
    logic [SW-1:0] arr_rdata;

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    always @(posedge clk_in) cycle_count <= cycle_count + 1;

    function automatic logic [SW-1:0] fill_value(input logic [SPW-1:0] s, input logic [TW-1:0] t);
        return {6'h2A, s, t, 12'h5C3, t};
    endfunction

    function automatic int onehot_to_idx(input logic [WAYS-1:0] oh);
        int idx = 0;
        for (int i = 0; i < WAYS; i++) if (oh[i]) idx = i;
        return idx;
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] required);
        tests++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
    endtask

    // Single-ported array with one-cycle read latency
    always @(posedge clk_in) begin
        if (access_en_out === 1'b1) begin
            if (write_en_out === 1'b1)
                arr_mem[int'(access_set_addr_out) * WAYS + onehot_to_idx(way_select_out)] <= write_single_data_out;
            else
                arr_rdata <= arr_mem[int'(access_set_addr_out) * WAYS + onehot_to_idx(way_select_out)];
        end
    end

    // Next level: accept the fill request after ready_delay cycles, return data after data_delay
    initial begin
        int phase;
        int cnt;
        logic [SPW-1:0] hs_set;
        logic [TW-1:0]  hs_tag;
        phase = 0;
        cnt = 0;
        hs_set = '0;
        hs_tag = '0;
        fill_req_ready_in = 1'b0;
        fill_valid_in = 1'b0;
        fill_data_in = '0;
        forever begin
            @(negedge clk_in);
            fill_valid_in = 1'b0;
            if (phase == 0) begin
                if (fill_req_valid_out === 1'b1) begin
                    if (cnt >= ready_delay) begin
                        fill_req_ready_in = 1'b1;
                        hs_set = fill_set_out;
                        hs_tag = fill_tag_out;
                        phase = 1;
                        cnt = 0;
                    end else begin
                        fill_req_ready_in = 1'b0;
                        if (spurious_en && cnt == 3) begin
                            fill_valid_in = 1'b1;
                            fill_data_in = 64'hBAD0_BAD0_BAD0_BAD0;
                        end
                        cnt++;
                    end
                end else begin
                    fill_req_ready_in = 1'b0;
                    cnt = 0;
                end
            end else begin
                fill_req_ready_in = 1'b0;
                if (cnt >= data_delay) begin
                    fill_valid_in = 1'b1;
                    fill_data_in = override_en ? override_data : fill_value(hs_set, hs_tag);
                    phase = 0;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Scoreboard monitor: pop and compare on every response
    always @(negedge clk_in) begin
        if (checks_on && reset_in && resp_valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_resp", 64'(resp_valid_out), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_output("resp_hit", 64'(resp_hit_out), 64'(e.exp_hit));
                check_output("resp_way", 64'(resp_way_out), 64'(e.exp_way));
                check_output("resp_latency", 64'(cycle_count - e.issue_cycle), 64'(e.exp_latency));
                if (!e.is_write) check_output("read_data", arr_rdata, e.exp_rdata);
            end
        end
    end

    // Protocol checks sampled just after each rising edge
    initial begin
        bit             prev_valid;
        logic [SPW-1:0] prev_set;
        logic [TW-1:0]  prev_tag;
        prev_valid = 1'b0;
        prev_set = '0;
        prev_tag = '0;
        forever begin
            @(posedge clk_in);
            #1;
            if (!checks_on || reset_in !== 1'b1) begin
                prev_valid = 1'b0;
            end else begin
                if (prev_valid && fill_req_ready_in !== 1'b1) begin
                    check_output("fill_req_held", 64'(fill_req_valid_out), 64'd1);
                    check_output("fill_set_stable", 64'(fill_set_out), 64'(prev_set));
                    check_output("fill_tag_stable", 64'(fill_tag_out), 64'(prev_tag));
                end
                if (prev_valid && fill_req_ready_in === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check_output("fill_without_request", 64'd1, 64'd0);
                    end else begin
                        check_output("fill_set", 64'(prev_set), 64'(exp_q[0].set));
                        check_output("fill_tag", 64'(prev_tag), 64'(exp_q[0].tag));
                    end
                end
                if (fill_req_valid_out === 1'b1 && !prev_valid) begin
                    if (exp_q.size() == 0) check_output("fill_req_no_request", 64'd1, 64'd0);
                    else check_output("fill_req_on_hit", 64'(exp_q[0].exp_hit), 64'd0);
                end
                if (fill_req_valid_out === 1'b1) check_output("ready_during_fill", 64'(req_ready_out), 64'd0);
                if (access_en_out !== 1'b1)
                    check_output("idle_enables", 64'({write_en_out, way_select_out}), 64'd0);
                else
                    check_output("way_onehot", 64'($onehot(way_select_out)), 64'd1);
                prev_valid = (fill_req_valid_out === 1'b1);
                prev_set = fill_set_out;
                prev_tag = fill_tag_out;
            end
        end
    end

    task automatic check_reset_outputs(input string tag_name);
        check_output({tag_name, "_ready"}, 64'(req_ready_out), 64'd1);
        check_output({tag_name, "_ctrl"},
                     64'({access_en_out, write_en_out, way_select_out, fill_req_valid_out,
                          resp_valid_out, resp_hit_out, resp_way_out, access_set_addr_out}), 64'd0);
        check_output({tag_name, "_fill"}, 64'({fill_set_out, fill_tag_out}), 64'd0);
        check_output({tag_name, "_wdata"}, write_single_data_out, 64'd0);
    endtask

    task automatic reset_dut(input string tag_name);
        @(negedge clk_in);
        reset_in = 1'b0;
        exp_q.delete();
        model_clear();
        #1;
        check_reset_outputs(tag_name);
        repeat (3) @(negedge clk_in);
        reset_in = 1'b1;
    endtask

    task automatic apply_stimulus(input logic wr, input logic [SPW-1:0] set, input logic [TW-1:0] tag,
                                  input logic [SW-1:0] data, input int rd, input int dd,
                                  input bit ovr_en, input logic [SW-1:0] ovr_data);
        int waited;
        bit hit;
        int way;
        exp_t e;
        waited = 0;
        @(negedge clk_in);
        while (req_ready_out !== 1'b1 && waited < 300) begin
            @(negedge clk_in);
            waited++;
        end
        if (req_ready_out !== 1'b1) begin
            check_output("req_ready_timeout", 64'(req_ready_out), 64'd1);
            return;
        end
        ready_delay = rd;
        data_delay = dd;
        override_en = ovr_en;
        override_data = ovr_data;

        hit = 1'b0;
        way = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && m_valid[set][w] && m_tag[set][w] == tag) begin
                hit = 1'b1;
                way = w;
            end
        end
        if (!hit) begin
            way = -1;
            for (int w = 0; w < WAYS; w++) if (way < 0 && !m_valid[set][w]) way = w;
            if (way < 0) begin
                way = m_ptr[set];
                m_ptr[set] = (m_ptr[set] + 1) % WAYS;
            end
            m_valid[set][way] = 1'b1;
            m_tag[set][way] = tag;
            m_data[set][way] = ovr_en ? ovr_data : fill_value(set, tag);
        end
        if (wr) m_data[set][way] = data;

        e.is_write = wr;
        e.set = set;
        e.tag = tag;
        e.exp_hit = hit;
        e.exp_way = WAYS'(1) << way;
        e.exp_rdata = m_data[set][way];
        e.issue_cycle = cycle_count;
        e.exp_latency = hit ? 2 : 6 + rd + dd;
        exp_q.push_back(e);

        req_valid_in = 1'b1;
        req_write_in = wr;
        req_set_in = set;
        req_tag_in = tag;
        req_data_in = data;
        @(negedge clk_in);
        req_valid_in = 1'b0;
        req_write_in = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        if (exp_q.size() != 0) check_output("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        reset_in = 1'b1;
        req_valid_in = 1'b0;
        req_write_in = 1'b0;
        req_set_in = '0;
        req_tag_in = '0;
        req_data_in = '0;
        ready_delay = 0;
        data_delay = 0;
        override_en = 1'b0;
        override_data = '0;
        spurious_en = 1'b0;
        tests = 0;
        errors = 0;
        model_clear();

        reset_dut("reset");
        checks_on = 1'b1;

        // First read misses and fills way 0; the repeat hits in two cycles
        apply_stimulus(1'b0, 6'd5, 20'h12345, '0, 0, 0, 1'b1, 64'hDEAD_BEEF);
        wait_drain(100);
        apply_stimulus(1'b0, 6'd5, 20'h12345, '0, 0, 0, 1'b0, '0);
        wait_drain(100);

        // Six distinct tags into set 3: ways 0-3, then round-robin ways 0 and 1
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b0, 6'd3, 20'h100 + 20'(i), '0, 0, 0, 1'b0, '0);
            wait_drain(100);
        end

        // Write-allocate miss followed by a read that returns the written data
        apply_stimulus(1'b1, 6'd7, 20'h1, 64'hA5, 0, 0, 1'b0, '0);
        wait_drain(100);
        apply_stimulus(1'b0, 6'd7, 20'h1, '0, 0, 0, 1'b0, '0);
        wait_drain(100);

        // Fill request held off for ten cycles with a stray fill pulse
        spurious_en = 1'b1;
        apply_stimulus(1'b0, 6'd20, 20'h4242, '0, 10, 0, 1'b0, '0);
        wait_drain(200);
        spurious_en = 1'b0;

        // Reset while waiting for fill data; the late fill pulse must be ignored
        apply_stimulus(1'b0, 6'd9, 20'h777, '0, 0, 20, 1'b0, '0);
        repeat (6) @(negedge clk_in);
        reset_dut("midfill_reset");
        repeat (30) @(negedge clk_in);
        check_output("post_reset_ready", 64'(req_ready_out), 64'd1);
        check_output("post_reset_access", 64'(access_en_out), 64'd0);
        apply_stimulus(1'b0, 6'd5, 20'h12345, '0, 0, 0, 1'b0, '0);
        wait_drain(100);

        // Randomized traffic over a few sets and a small tag pool
        for (int i = 0; i < 250; i++) begin
            apply_stimulus($urandom_range(0, 2) == 0,
                           6'(10 + $urandom_range(0, 3)),
                           20'($urandom_range(0, 6)),
                           {$urandom, $urandom},
                           int'($urandom_range(0, 3)),
                           int'($urandom_range(0, 3)),
                           1'b0, '0);
        end
        wait_drain(500);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/associative_way_controller.md
# associative_way_controller

Request-side controller that sits directly upstream of the set-associative data array. It holds the per-set tag/valid state in flops and resolves each request to a hit way or a victim way. On a miss it runs a fill handshake to the next level and writes the returned element into the victim way. It then replays the request and drives the data array's access/write enables, set address, one-hot way select and write data.

## Interface
Parameters:
- SINGLE_ELEMENT_SIZE_IN_BITS, 64, element width; matches data array.
- NUMBER_SETS, 64, sets per way.
- NUMBER_WAYS, 4, associativity; power of two, ≥2.
- TAG_WIDTH_IN_BITS, 20, stored tag width.
- SET_PTR_WIDTH_IN_BITS, $clog2(NUMBER_SETS), set index width.

Ports:
- clk_in  input  1  single clock; all logic on rising edge.
- reset_in  input  1  asynchronous, active-low reset.
- req_valid_in  input  1  request present.
- req_ready_out  output  1  controller accepts request this cycle.
- req_write_in  input  1  1 = write, 0 = read.
- req_set_in  input  SET_PTR_WIDTH_IN_BITS  set index.
- req_tag_in  input  TAG_WIDTH_IN_BITS  tag.
- req_data_in  input  SINGLE_ELEMENT_SIZE_IN_BITS  write data.
- access_en_out  output  1  data array access enable.
- write_en_out  output  1  data array write enable.
- access_set_addr_out  output  SET_PTR_WIDTH_IN_BITS  data array set address.
- way_select_out  output  NUMBER_WAYS  one-hot way select.
- write_single_data_out  output  SINGLE_ELEMENT_SIZE_IN_BITS  data array write data.
- fill_req_valid_out  output  1  fill request to next level.
- fill_req_ready_in  input  1  next level accepts fill request.
- fill_set_out  output  SET_PTR_WIDTH_IN_BITS  fill set.
- fill_tag_out  output  TAG_WIDTH_IN_BITS  fill tag.
- fill_valid_in  input  1  fill data returned (single-cycle pulse).
- fill_data_in  input  SINGLE_ELEMENT_SIZE_IN_BITS  fill data.
- resp_valid_out  output  1  request completed; read data valid on data array output this cycle.
- resp_hit_out  output  1  1 if first lookup hit, 0 if fill was needed.
- resp_way_out  output  NUMBER_WAYS  one-hot way that served the request.

## Operation
- State per set/way: valid bit and tag. Per set: round-robin victim pointer, $clog2(NUMBER_WAYS) bits.
- FSM states: IDLE, LOOKUP, FILL_REQ, FILL_WAIT, FILL_WRITE, RESP.
- IDLE:
  - req_ready_out=1.
  - On req_valid_in, register write/set/tag/data, clear the missed flag, go to LOOKUP.
- LOOKUP:
  - Compare registered tag against all valid ways of the set.
  - Hit: access_en_out=1, way_select_out=hit one-hot, write_en_out=registered write, write_single_data_out=registered data; go to RESP.
  - Miss: set the missed flag; victim = lowest-index invalid way, else the way at the set's round-robin pointer; go to FILL_REQ.
  - More than one matching way cannot occur; the lowest index wins.
- FILL_REQ:
  - fill_req_valid_out=1 with fill_set_out/fill_tag_out held stable.
  - On fill_req_ready_in, go to FILL_WAIT.
- FILL_WAIT:
  - On fill_valid_in, capture fill_data_in, go to FILL_WRITE.
  - fill_valid_in is ignored in every other state.
- FILL_WRITE:
  - access_en_out=1, write_en_out=1, victim one-hot, write_single_data_out=fill data.
  - Set the victim's valid bit and tag.
  - If the victim was chosen by the pointer, advance the pointer by 1 (wraps at NUMBER_WAYS-1 → 0).
  - Go to LOOKUP (replay, which now hits). Write misses are write-allocate: fill first, then the replayed write overwrites.
- RESP:
  - resp_valid_out=1 for one cycle.
  - resp_hit_out = !missed flag.
  - resp_way_out = way used by the replayed access.
  - Go to IDLE.
- No response backpressure.

## Timing
- Reset (reset_in=0, asynchronous):
  - FSM → IDLE; all valid bits and victim pointers cleared.
  - All outputs 0 except req_ready_out=1.
  - Reset mid-fill abandons the fill; a fill_valid_in arriving after reset is ignored.
- Hit (accept in cycle T): access in T+1, resp_valid_out in T+2. This matches the one-cycle array read latency, so read data is valid with resp_valid_out.
- Miss: accept T; LOOKUP T+1; FILL_REQ from T+2 until handshake; FILL_WAIT ≥1 cycle; FILL_WRITE; LOOKUP; RESP.
  - Minimum total with ready and fill both immediate: resp in T+6.
- Throughput: at most one request per 3 cycles. req_ready_out is 0 outside IDLE.
- fill_req_valid_out, once raised, stays high with stable set/tag until fill_req_ready_in.
- access_en_out, write_en_out and way_select_out are driven only in LOOKUP-hit and FILL_WRITE cycles; otherwise all are 0.

## Test plan
- Reset, then read set 5, tag 0x12345 → miss; fill request with set 5, tag 0x12345; fill 0xDEAD_BEEF → way 0 written; resp in T+6 with hit=0, way=0001.
- Repeat the same read → resp at T+2, hit=1, way=0001, no fill_req_valid_out.
- Fill set 3 with four distinct tags (ways 0–3), then a fifth tag → victim way 0 (pointer 0, advances to 1); a sixth new tag → victim way 1.
- Write miss set 7, tag 0x1, data 0xA5 → fill written, then replayed write with write_en_out=1, data 0xA5; a following read hits with the array returning 0xA5.
- Hold fill_req_ready_in low for 10 cycles → fill_req_valid_out, set and tag stable; req_ready_out=0 throughout; spurious fill_valid_in during FILL_REQ is ignored.
- Assert reset_in=0 during FILL_WAIT → outputs zero immediately, req_ready_out=1 after release; the earlier-hit set now misses (valids cleared).
